// File: rtl/id_decode_stage_pkg.sv
// Shared definitions for the venus ID stage: class codes, instruction field positions
// and the one-hot class control bundle.
package venus_id_pkg;

   localparam logic [2:0] CLS_INTE  = 3'd0;
   localparam logic [2:0] CLS_LOGIC = 3'd1;
   localparam logic [2:0] CLS_SHIFT = 3'd2;
   localparam logic [2:0] CLS_LD    = 3'd3;
   localparam logic [2:0] CLS_ST    = 3'd4;
   localparam logic [2:0] CLS_BR    = 3'd5;

   localparam int OPC_MSB  = 31;
   localparam int OPC_LSB  = 25;
   localparam int IMMF_BIT = 24;
   localparam int RD_LSB   = 20;
   localparam int RS_LSB   = 16;
   localparam int IMM_MSB  = 15;
   localparam int IMM_LSB  = 0;

   typedef struct packed {
      logic inte;
      logic logical;
      logic shift;
      logic ld;
      logic st;
      logic br;
      logic illegal;
   } ctrl_t;

   // Classes 6 and 7 are undefined and decode to illegal only.
   function automatic ctrl_t class_ctrl(input logic [2:0] cls);
      ctrl_t c;
      c = '0;
      case (cls)
         CLS_INTE:  c.inte    = 1'b1;
         CLS_LOGIC: c.logical = 1'b1;
         CLS_SHIFT: c.shift   = 1'b1;
         CLS_LD:    c.ld      = 1'b1;
         CLS_ST:    c.st      = 1'b1;
         CLS_BR:    c.br      = 1'b1;
         default:   c.illegal = 1'b1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/id_decode_stage_if.sv
// IF/EX-facing bus of the ID stage, including the write-back port.
// slave = the decode stage, master = the surrounding pipeline.
interface id_decode_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4
);
   logic [31:0]       inst_i;
   logic              inst_valid_i;
   logic              stall_i;
   logic              stall_o;
   logic              valid_o;
   logic [REG_AW-1:0] rd_idx_o;
   logic [DATA_W-1:0] rd_value_o;
   logic [DATA_W-1:0] rs_value_o;
   logic [DATA_W-1:0] imm_value_o;
   logic              immf_o;
   logic              ctrl_inte_o;
   logic              ctrl_logic_o;
   logic              ctrl_shift_o;
   logic              ctrl_ld_o;
   logic              ctrl_st_o;
   logic              ctrl_br_o;
   logic              illegal_o;
   logic [REG_AW-1:0] wb_r_i;
   logic              wb_i;
   logic [DATA_W-1:0] wb_data_i;

   modport slave (
      input  inst_i, inst_valid_i, stall_i, wb_r_i, wb_i, wb_data_i,
      output stall_o, valid_o, rd_idx_o, rd_value_o, rs_value_o, imm_value_o, immf_o,
             ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o,
             illegal_o
   );

   modport master (
      output inst_i, inst_valid_i, stall_i, wb_r_i, wb_i, wb_data_i,
      input  stall_o, valid_o, rd_idx_o, rd_value_o, rs_value_o, imm_value_o, immf_o,
             ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o,
             illegal_o
   );
endinterface

// File: rtl/id_decode_stage_regfile.sv
// Register file: 2 async read ports, 1 sync write port, async active-low clear.
// Define ID_WB_BYPASS_EN to forward a same-cycle write into each read port.
module id_regfile #(
   parameter int DATA_W = 32,
   parameter int NREG   = 16,
   parameter int REG_AW = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] ra_a,
   input  logic [REG_AW-1:0] ra_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   input  logic              we,
   input  logic [REG_AW-1:0] wa,
   input  logic [DATA_W-1:0] wdata
);

   logic [DATA_W-1:0] mem [NREG];
   logic [DATA_W-1:0] raw_a;
   logic [DATA_W-1:0] raw_b;

   // Flop-based storage: the whole file must clear on reset, which rules out block RAM.
   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
         logic [DATA_W-1:0] q_reg;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               q_reg <= '0;
            end else if (we && (wa == REG_AW'(gi))) begin
               q_reg <= wdata;
            end
         end
         assign mem[gi] = q_reg;
      end
   endgenerate

   assign raw_a = (int'(ra_a) < NREG) ? mem[ra_a] : '0;
   assign raw_b = (int'(ra_b) < NREG) ? mem[ra_b] : '0;

`ifdef ID_WB_BYPASS_EN
   assign rdata_a = (we && (wa == ra_a)) ? wdata : raw_a;
   assign rdata_b = (we && (wa == ra_b)) ? wdata : raw_b;
`else
   assign rdata_a = raw_a;
   assign rdata_b = raw_b;
`endif

endmodule

// File: rtl/id_decode_stage.sv
// venus ID stage: decodes the instruction, reads operands, registers them with valid,
// stall hold and load-use bubble insertion. ID_WB_BYPASS_EN enables write-back forwarding.
module id_decode_stage
   import venus_id_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NREG   = 16,
   parameter int REG_AW = $clog2(NREG)
) (
   input logic          clk,
   input logic          rst,
   id_decode_stage_if.slave bus
);

   logic [2:0]        cls;
   logic [REG_AW-1:0] rd_f;
   logic [REG_AW-1:0] rs_f;
   logic [15:0]       imm_f;
   ctrl_t             dec_ctrl;
   logic [DATA_W-1:0] imm_ext;
   logic [DATA_W-1:0] rf_rd;
   logic [DATA_W-1:0] rf_rs;
   logic              hazard;
   logic              unused_inst;

   logic              valid_reg;
   logic [REG_AW-1:0] rd_idx_reg;
   logic [DATA_W-1:0] rd_value_reg;
   logic [DATA_W-1:0] rs_value_reg;
   logic [DATA_W-1:0] imm_value_reg;
   logic              immf_reg;
   ctrl_t             ctrl_reg;

   assign cls         = bus.inst_i[OPC_MSB -: 3];
   assign rd_f        = bus.inst_i[RD_LSB +: REG_AW];
   assign rs_f        = bus.inst_i[RS_LSB +: REG_AW];
   assign imm_f       = bus.inst_i[IMM_MSB:IMM_LSB];
   assign dec_ctrl    = class_ctrl(cls);
   assign unused_inst = ^{bus.inst_i[OPC_LSB +: 4]};

   assign imm_ext = (cls == CLS_LOGIC) ? DATA_W'(imm_f) : DATA_W'(signed'(imm_f));

   id_regfile #(
      .DATA_W (DATA_W),
      .NREG   (NREG),
      .REG_AW (REG_AW)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .ra_a    (rd_f),
      .ra_b    (rs_f),
      .rdata_a (rf_rd),
      .rdata_b (rf_rs),
      .we      (bus.wb_i),
      .wa      (bus.wb_r_i),
      .wdata   (bus.wb_data_i)
   );

   // A load in EX cannot supply its result this cycle, so a dependent instruction must wait.
   assign hazard = valid_reg & ctrl_reg.ld & bus.inst_valid_i &
                   ((rs_f == rd_idx_reg) | (rd_f == rd_idx_reg));

   assign bus.stall_o = bus.stall_i | hazard;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_reg     <= 1'b0;
         rd_idx_reg    <= '0;
         rd_value_reg  <= '0;
         rs_value_reg  <= '0;
         imm_value_reg <= '0;
         immf_reg      <= 1'b0;
         ctrl_reg      <= '0;
      end else if (bus.stall_i) begin
         valid_reg <= valid_reg;
      end else if (hazard) begin
         // Operands are held; the instruction is re-presented by IF next cycle.
         valid_reg <= 1'b0;
         ctrl_reg  <= '0;
      end else begin
         valid_reg     <= bus.inst_valid_i;
         rd_idx_reg    <= rd_f;
         rd_value_reg  <= rf_rd;
         rs_value_reg  <= rf_rs;
         imm_value_reg <= imm_ext;
         immf_reg      <= bus.inst_i[IMMF_BIT];
         ctrl_reg      <= bus.inst_valid_i ? dec_ctrl : '0;
      end
   end

   assign bus.valid_o      = valid_reg;
   assign bus.rd_idx_o     = rd_idx_reg;
   assign bus.rd_value_o   = rd_value_reg;
   assign bus.rs_value_o   = rs_value_reg;
   assign bus.imm_value_o  = imm_value_reg;
   assign bus.immf_o       = immf_reg;
   assign bus.ctrl_inte_o  = ctrl_reg.inte;
   assign bus.ctrl_logic_o = ctrl_reg.logical;
   assign bus.ctrl_shift_o = ctrl_reg.shift;
   assign bus.ctrl_ld_o    = ctrl_reg.ld;
   assign bus.ctrl_st_o    = ctrl_reg.st;
   assign bus.ctrl_br_o    = ctrl_reg.br;
   assign bus.illegal_o    = ctrl_reg.illegal;

endmodule
